// File: rtl/lenet_conv_kxk_stream.sv
`default_nettype none
// ============================================================================
// Module      : lenet_conv_kxk_stream
// Description : Streaming KxK convolution over a raster pixel stream. It uses
//               K-1 line buffers, a KxK window and a registered adder tree.
//               Define LENET_CONV_RELU_EN to clamp negative sums to zero.
// Revision    : 1.0
// ============================================================================
module lenet_conv_kxk_stream #(
  parameter int WD    = 3,
  parameter int WW    = 8,
  parameter int K     = 5,
  parameter int IMG_W = 14,
  localparam int AW   = $clog2(K*K),
  localparam int TS   = $clog2(K*K),
  localparam int OW   = WD + WW + 1 + TS,
  localparam int LAT  = 2 + TS
) (
  input  logic                 i_sclk,
  input  logic                 i_rst,
  input  logic                 i_vsync,
  input  logic                 i_hsync,
  input  logic                 i_valid,
  input  logic [WD-1:0]        i_tdata,
  input  logic                 i_W_en,
  input  logic [AW-1:0]        i_W_addr,
  input  logic [WW-1:0]        i_Weight,
  output logic                 o_hsync,
  output logic                 o_valid,
  output logic [OW-1:0]        o_tdata,
  output logic                 o_err
);

  localparam int KK = K * K;
  localparam int NL = 1 << TS;
  localparam int CW = $clog2(IMG_W + 1);
  localparam int IW = $clog2(IMG_W);
  localparam logic [CW-1:0] COL_LIM = CW'(IMG_W);
  localparam logic [CW-1:0] COL_MIN = CW'(K - 1);
  localparam logic [7:0]    ROW_MIN = 8'(K - 1);
  localparam logic [AW:0]   KK_W    = (AW + 1)'(KK);

  logic [CW-1:0]        col, col_cur;
  logic [7:0]           row, row_cur;
  logic                 synced, active, accept, overlong;
  logic                 win_fire, hs_fire, clear, err;
  logic [IW-1:0]        lb_idx;
  logic [WD-1:0]        lb   [K-1][IMG_W];
  logic [WD-1:0]        colv [K];
  logic [WD-1:0]        win  [KK];
  logic signed [WW-1:0] wgt  [KK];
  logic [LAT-1:0]       vpipe, hpipe;
  // Heap-ordered adder tree: node[1] is the root, leaves start at NL.
  logic signed [OW-1:0] node [1:2*NL-1];

  // A vsync-coincident pixel belongs to column 0, row 0 of the new frame.
  always_comb begin
    active   = synced | i_vsync;
    col_cur  = i_vsync ? '0 : col;
    row_cur  = i_vsync ? '0 : row;
    accept   = i_valid & active & (col_cur < COL_LIM);
    overlong = i_valid & active & (col_cur >= COL_LIM);
    win_fire = accept & (row_cur >= ROW_MIN) & (col_cur >= COL_MIN);
    hs_fire  = i_hsync & ~i_vsync & synced & (row >= ROW_MIN);
    clear    = i_rst | i_vsync;
    lb_idx   = col_cur[IW-1:0];
  end

  // After reset nothing is produced until a fresh frame start is seen.
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      col    <= '0;
      row    <= '0;
      synced <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (i_vsync) begin
        synced <= 1'b1;
        row    <= '0;
        col    <= accept ? CW'(1) : '0;
      end else if (synced) begin
        if (i_hsync) begin
          col <= '0;
          if (row != 8'hFF) row <= row + 8'd1;
        end else if (accept) begin
          col <= col + CW'(1);
        end
      end
      if (overlong) err <= 1'b1;
    end
  end

  always_comb begin
    colv[K-1] = i_tdata;
    for (int j = 0; j < K - 1; j++) colv[K-2-j] = lb[j][lb_idx];
  end

  always_ff @(posedge i_sclk) begin
    if (accept) begin
      lb[0][lb_idx] <= i_tdata;
      for (int j = 1; j < K - 1; j++) lb[j][lb_idx] <= lb[j-1][lb_idx];
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win[r*K+c] <= win[r*K+c+1];
        win[r*K+K-1] <= colv[r];
      end
    end
  end

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      for (int i = 0; i < KK; i++) wgt[i] <= '0;
    end else if (i_W_en && ({1'b0, i_W_addr} < KK_W)) begin
      wgt[i_W_addr] <= i_Weight;
    end
  end

  always_ff @(posedge i_sclk) begin
    if (clear) begin
      vpipe <= '0;
      hpipe <= '0;
    end else begin
      vpipe <= {vpipe[LAT-2:0], win_fire};
      hpipe <= {hpipe[LAT-2:0], hs_fire};
    end
  end

  // Invalid slots carry zeros, so the root is zero whenever o_valid is low.
  always_ff @(posedge i_sclk) begin
    if (clear) begin
      for (int i = 1; i < 2 * NL; i++) node[i] <= '0;
    end else begin
      for (int i = 1; i < NL; i++) node[i] <= node[2*i] + node[2*i+1];
      for (int j = 0; j < KK; j++)
        node[NL+j] <= vpipe[0] ? OW'(wgt[j]) * OW'($signed({1'b0, win[j]})) : '0;
      for (int j = KK; j < NL; j++) node[NL+j] <= '0;
    end
  end

  assign o_valid = vpipe[LAT-1];
  assign o_hsync = hpipe[LAT-1];
  assign o_err   = err;
`ifdef LENET_CONV_RELU_EN
  assign o_tdata = node[1][OW-1] ? '0 : node[1];
`else
  assign o_tdata = node[1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_lenet_conv_kxk_stream.sv
`default_nettype none
// Directed bench for lenet_conv_kxk_stream: 14x14 frames with hand-derived
// window sums, latency, hsync, overlong-line, reset and gapped-input cases.
module tb_lenet_conv_kxk_stream;

  localparam int WD = 3, WW = 8, K = 5, IMG_W = 14;
  localparam int AW = 5, OW = 17, LAT = 7;

  logic clk = 1'b0;
  logic i_rst = 1'b1, i_vsync = 1'b0, i_hsync = 1'b0, i_valid = 1'b0;
  logic [WD-1:0] i_tdata = '0;
  logic i_W_en = 1'b0;
  logic [AW-1:0] i_W_addr = '0;
  logic [WW-1:0] i_Weight = '0;
  logic o_hsync, o_valid, o_err;
  logic [OW-1:0] o_tdata;

  lenet_conv_kxk_stream #(.WD(WD), .WW(WW), .K(K), .IMG_W(IMG_W)) dut (
    .i_sclk(clk), .i_rst(i_rst), .i_vsync(i_vsync), .i_hsync(i_hsync),
    .i_valid(i_valid), .i_tdata(i_tdata), .i_W_en(i_W_en),
    .i_W_addr(i_W_addr), .i_Weight(i_Weight), .o_hsync(o_hsync),
    .o_valid(o_valid), .o_tdata(o_tdata), .o_err(o_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  int n_out = 0, n_hs = 0;
  int eq_val[$], eq_cyc[$], hq_cyc[$];
  bit mon_en = 1'b0;
  int mode = 0;
  int brow = 0, bcol = 0;
  bit bsync = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pixv(input int m, input int r, input int c);
    return (m == 1) ? (r + c) % 8 : 7;
  endfunction

  function automatic int expv(input int m, input int r, input int c);
    case (m)
      0: return 175;
      1: return (r + c - 4) % 8;
`ifdef LENET_CONV_RELU_EN
      2: return 0;
`else
      2: return -175;
`endif
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin : mon
    int ev, ec;
    if (mon_en) begin
      if (o_valid) begin
        n_out++;
        if (eq_val.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          ev = eq_val.pop_front();
          ec = eq_cyc.pop_front();
          check("sum", longint'($signed(o_tdata)), ev);
          check("latency", cyc, ec);
        end
      end else begin
        check("idle_zero", o_tdata, 0);
      end
      if (o_hsync) begin
        n_hs++;
        if (hq_cyc.size() == 0) check("unexpected_hsync", 1, 0);
        else check("hsync_latency", cyc, hq_cyc.pop_front());
      end
    end
  end

  // Results due at or after a clearing edge never appear.
  task automatic trim(input int edge_cyc);
    while (eq_cyc.size() > 0 && eq_cyc[$] >= edge_cyc) begin
      void'(eq_cyc.pop_back());
      void'(eq_val.pop_back());
    end
    while (hq_cyc.size() > 0 && hq_cyc[$] >= edge_cyc) void'(hq_cyc.pop_back());
  endtask

  task automatic idle(input int n);
    i_valid = 0; i_hsync = 0; i_vsync = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr_w(input int a, input int v);
    i_W_en = 1; i_W_addr = AW'(a); i_Weight = WW'(v);
    @(posedge clk); #1;
    i_W_en = 0;
  endtask

  task automatic set_all(input int v);
    for (int a = 0; a < K * K; a++) wr_w(a, v);
  endtask

  task automatic vsync_pulse();
    i_valid = 0; i_hsync = 0; i_vsync = 1;
    brow = 0; bcol = 0; bsync = 1;
    @(posedge clk); #1;
    trim(cyc);
    i_vsync = 0;
  endtask

  task automatic pix(input int v, input bit vs);
    bit fire;
    int ev;
    if (vs) begin brow = 0; bcol = 0; bsync = 1; end
    i_valid = 1; i_hsync = 0; i_vsync = vs; i_tdata = WD'(v);
    fire = bsync && brow >= K - 1 && bcol >= K - 1 && bcol < IMG_W;
    ev = expv(mode, brow, bcol);
    @(posedge clk); #1;
    if (vs) trim(cyc);
    if (fire) begin eq_val.push_back(ev); eq_cyc.push_back(cyc + LAT - 1); end
    bcol++;
    i_vsync = 0;
  endtask

  task automatic hsync_pulse();
    bit fire;
    i_valid = 0; i_vsync = 0; i_hsync = 1;
    fire = bsync && brow >= K - 1;
    @(posedge clk); #1;
    if (fire) hq_cyc.push_back(cyc + LAT - 1);
    brow++; bcol = 0;
    i_hsync = 0;
  endtask

  task automatic do_reset();
    i_valid = 0; i_hsync = 0; i_vsync = 0; i_rst = 1;
    @(posedge clk); #1;
    trim(cyc);
    i_rst = 0; bsync = 0;
  endtask

  task automatic frame(input int m, input bit gap, input int long_row,
                       input int rst_row, input bit vs_co);
    int width;
    mode = m; n_out = 0; n_hs = 0;
    if (!vs_co) vsync_pulse();
    for (int r = 0; r < 14; r++) begin
      width = (r == long_row) ? 16 : 14;
      for (int c = 0; c < width; c++) begin
        if (r == rst_row && c == 8) do_reset();
        pix(pixv(m, r, c), vs_co && r == 0 && c == 0);
        if (gap) idle(1);
      end
      hsync_pulse();
      idle(1);
    end
    idle(12);
    check("drain_sum", eq_val.size(), 0);
    check("drain_hsync", hq_cyc.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_hsync", o_hsync, 0);
    check("rst_tdata", o_tdata, 0);
    check("rst_err", o_err, 0);
    i_rst = 0;
    mon_en = 1;
    idle(3);

    set_all(1);
    frame(0, 0, -1, -1, 0);
    check("ones_outputs", n_out, 100);
    check("ones_hsyncs", n_hs, 10);

    set_all(0);
    wr_w(12, 1);
    frame(1, 0, -1, -1, 0);
    check("centre_outputs", n_out, 100);

    set_all(-1);
    frame(2, 0, -1, -1, 0);
    check("neg_outputs", n_out, 100);
    check("pre_long_err", o_err, 0);

    set_all(1);
    frame(0, 0, 3, -1, 0);
    check("long_outputs", n_out, 100);
    check("long_hsyncs", n_hs, 10);
    check("long_err", o_err, 1);
    vsync_pulse();
    idle(3);
    check("err_after_vsync", o_err, 1);

    frame(0, 1, -1, -1, 1);
    check("gap_outputs", n_out, 100);
    check("gap_hsyncs", n_hs, 10);

    frame(0, 0, -1, 8, 0);
    check("rst_err_cleared", o_err, 0);
    frame(3, 0, -1, -1, 0);
    check("post_rst_outputs", n_out, 100);
    check("post_rst_hsyncs", n_hs, 10);

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lenet_conv_kxk_stream.md
LENET_CONV_KXK_STREAM -- requirements
Module: lenet_conv_kxk_stream

Interface
REQ-001 SHALL provide parameter WD, default 3, unsigned pixel width.
REQ-002 SHALL provide parameter WW, default 8, signed two's-complement weight width.
REQ-003 SHALL provide parameter K, default 5, kernel side, legal range 2..7.
REQ-004 SHALL provide parameter IMG_W, default 14, maximum pixels per input line, legal range K..255.
REQ-005 SHALL derive localparams AW = clog2(K*K), TS = clog2(K*K), OW = WD+WW+1+TS, LAT = 2+TS.
REQ-006 i_sclk  in  1  sole clock; all logic on its rising edge.
REQ-007 i_rst  in  1  reset, synchronous, active-high.
REQ-008 i_vsync  in  1  one-cycle frame-start pulse; precedes the first pixel of a frame.
REQ-009 i_hsync  in  1  one-cycle end-of-line pulse; follows the last pixel of a line.
REQ-010 i_valid  in  1  pixel qualifier; pixels of one line may have gaps.
REQ-011 i_tdata  in  WD  unsigned pixel.
REQ-012 i_W_en / i_W_addr[AW-1:0] / i_Weight[WW-1:0]  in  weight write port; addr = row*K+col, row 0 = oldest line, col 0 = oldest pixel.
REQ-013 o_hsync  out  1  end-of-output-line pulse.
REQ-014 o_valid  out  1  o_tdata qualifier.
REQ-015 o_tdata  out  OW  signed window sum.
REQ-016 o_err  out  1  sticky overlong-line flag.

Function
REQ-017 SHALL hold K-1 internal line buffers of depth IMG_W, WD bits wide, and a KxK window register array fed by the current pixel and the K-1 buffered pixels at the same column.
REQ-018 SHALL count columns (reset to 0 on i_hsync, i_vsync) and rows (reset to 0 on i_vsync, +1 on i_hsync, saturating at 255).
REQ-019 SHALL form a window when a pixel is accepted with row >= K-1 and col >= K-1 (col = index before increment).
REQ-020 SHALL compute sum over r,c of W[r*K+c] * pixel, pixels zero-extended to WD+1 bits signed, products WD+WW+1 bits, sign-extended through an adder tree of TS registered stages.
REQ-021 SHALL present o_valid=1 and the window sum exactly LAT cycles after the accepting i_valid cycle; o_tdata SHALL be 0 whenever o_valid=0.
REQ-022 SHALL pulse o_hsync for one cycle LAT cycles after an i_hsync whose row count (before increment) is >= K-1.
REQ-023 SHALL ignore pixels with col >= IMG_W (no buffer write, no window) and set o_err; o_err clears only on i_rst.
REQ-024 SHALL ignore i_Weight addresses >= K*K; a write SHALL take effect for windows accepted on the following cycle or later.
REQ-025 SHALL, on i_vsync, clear counters and all pipeline valid bits, discard in-flight results, and retain weights and o_err.
REQ-026 SHALL, when i_vsync and i_valid coincide, treat the pixel as column 0 row 0 of the new frame.

Reset
REQ-027 On i_rst SHALL clear all weights, counters, pipeline valid bits, o_valid, o_hsync, o_tdata and o_err to 0; line-buffer contents need not be cleared.
REQ-028 Reset asserted mid-frame SHALL suppress all outputs from the next cycle until K-1 full lines of a new frame arrive.

Configuration
REQ-029 With macro LENET_CONV_RELU_EN defined, o_tdata SHALL be max(sum,0) at the same LAT; without it o_tdata SHALL be the raw signed sum.

Verification
REQ-030 K=5, IMG_W=14, all weights 1, 14x14 frame of pixel 7 -> 10 rows x 10 outputs of 175, each LAT=7 cycles after its pixel, 10 o_hsync pulses.
REQ-031 Only W[12]=1, ramp pixel=(row+col)%8 -> output at (r,c) equals pixel (r-2,c-2), i.e. window centre.
REQ-032 All weights -1, pixels 7 -> o_tdata=-175 without macro; 0 with LENET_CONV_RELU_EN.
REQ-033 One 16-pixel line in a 14-wide frame -> o_err=1, identical outputs to the 14-pixel case, o_err persists across i_vsync.
REQ-034 i_rst for one cycle during row 8 -> o_valid stays 0 until row 4 of the next frame; weights read back as 0 (all outputs 0).
REQ-035 Gapped i_valid (every other cycle) -> same 100 results, each exactly 7 cycles after its pixel.
